// File: rtl/cache_traffic_gen_if.sv
// Cache port bundle: request channel (generator -> cache) and response
// channel (cache -> generator), both val/rdy.
interface cache_traffic_gen_if;
  logic [75:0] cachereq_msg;   // {type, opaque, addr, len, data}
  logic        cachereq_val;
  logic        cachereq_rdy;
  logic [43:0] cacheresp_msg;  // {type, opaque, len, data}
  logic        cacheresp_val;
  logic        cacheresp_rdy;

  modport master (
    output cachereq_msg, cachereq_val, cacheresp_rdy,
    input  cachereq_rdy, cacheresp_msg, cacheresp_val
  );

  modport slave (
    input  cachereq_msg, cachereq_val, cacheresp_rdy,
    output cachereq_rdy, cacheresp_msg, cacheresp_val
  );
endinterface

// File: rtl/cache_traffic_gen.sv
// Cache traffic generator: write sweep then read-back sweep over a tag/index
// pattern, one request in flight, every response checked against the
// expected opaque/type/data. Exposes pass/fail and progress counters.
module cache_traffic_gen #(
  parameter int          NUM_REQS  = 50,
  parameter int          TAG_COUNT = 4,
  parameter int          IDX_COUNT = 4,
  parameter int          OFFSET    = 0,
  parameter logic [31:0] DATA_SEED = 32'h0000_0000,
  parameter int          GAP       = 0,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  cache_traffic_gen_if.master        cache,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [7:0]                 err_count,
  output logic [8:0]                 req_count,
  output logic [8:0]                 resp_count
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      LAST_I   = 8'(NUM_REQS - 1);
  localparam logic [2:0]      TAG_LAST = 3'(TAG_COUNT - 1);
  localparam logic [2:0]      IDX_LAST = 3'(IDX_COUNT - 1);
  localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0]      OFF      = 4'(OFFSET);
  localparam logic [1:0]      T_RD     = 2'd0;
  localparam logic [1:0]      T_WR     = 2'd1;

  typedef enum logic [2:0] {
    IDLE, GAP_WAIT, SEND, WAIT_RESP, DONE
  } state_t;

  // Registered state
  state_t        r_state;
  logic [7:0]    r_seq;       // step index i within the current phase
  logic [2:0]    r_tag;
  logic [2:0]    r_idx;
  logic          r_rd;        // 0 = write phase, 1 = read phase
  logic [7:0]    r_gap;
  logic [TW-1:0] r_timer;
  logic          r_req_val;
  logic [75:0]   r_req_msg;
  logic          r_resp_rdy;
  logic          r_done;
  logic          r_pass;
  logic          r_timeout;
  logic [7:0]    r_err;
  logic [8:0]    r_reqc;
  logic [8:0]    r_respc;

  // Next-state values
  state_t        w_state;
  logic [7:0]    w_seq;
  logic [2:0]    w_tag;
  logic [2:0]    w_idx;
  logic          w_rd;
  logic [7:0]    w_gap;
  logic [TW-1:0] w_timer;
  logic          w_req_val;
  logic [75:0]   w_req_msg;
  logic          w_resp_rdy;
  logic          w_done;
  logic          w_pass;
  logic          w_timeout;
  logic [7:0]    w_err;
  logic [8:0]    w_reqc;
  logic [8:0]    w_respc;
  logic          w_load;      // build a fresh request message this cycle

  // Response fields and check against the outstanding request
  logic [1:0]    w_rsp_type;
  logic [7:0]    w_rsp_op;
  logic [1:0]    w_unused_len;
  logic [31:0]   w_rsp_data;
  logic          w_mismatch;
  logic          w_last_read;

  assign {w_rsp_type, w_rsp_op, w_unused_len, w_rsp_data} = cache.cacheresp_msg;

  assign w_mismatch  = (w_rsp_op != r_seq)
                     | (w_rsp_type != (r_rd ? T_RD : T_WR))
                     | (r_rd & (w_rsp_data != (DATA_SEED + {24'd0, r_seq})));
  assign w_last_read = r_rd & (r_seq == LAST_I);

  assign cache.cachereq_val  = r_req_val;
  assign cache.cachereq_msg  = r_req_msg;
  assign cache.cacheresp_rdy = r_resp_rdy;

  assign busy       = (r_state != IDLE) && (r_state != DONE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign err_count  = r_err;
  assign req_count  = r_reqc;
  assign resp_count = r_respc;

  // Next-state and registered-output logic for the sweep FSM
  always_comb begin
    w_state    = r_state;
    w_seq      = r_seq;
    w_tag      = r_tag;
    w_idx      = r_idx;
    w_rd       = r_rd;
    w_gap      = r_gap;
    w_timer    = r_timer;
    w_req_val  = r_req_val;
    w_req_msg  = r_req_msg;
    w_resp_rdy = r_resp_rdy;
    w_done     = r_done;
    w_pass     = r_pass;
    w_timeout  = r_timeout;
    w_err      = r_err;
    w_reqc     = r_reqc;
    w_respc    = r_respc;
    w_load     = 1'b0;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_seq     = 8'd0;
          w_tag     = 3'd0;
          w_idx     = 3'd0;
          w_rd      = 1'b0;
          w_err     = 8'd0;
          w_reqc    = 9'd0;
          w_respc   = 9'd0;
          w_timeout = 1'b0;
          w_pass    = 1'b0;
          w_done    = 1'b0;
          w_req_val = 1'b1;
          w_load    = 1'b1;
          w_state   = SEND;
        end
      end

      GAP_WAIT: begin
        if (r_gap == GAP_LAST) begin
          w_req_val = 1'b1;
          w_load    = 1'b1;
          w_state   = SEND;
        end else begin
          w_gap = r_gap + 8'd1;
        end
      end

      SEND: begin
        if (cache.cachereq_rdy) begin
          w_req_val  = 1'b0;
          w_reqc     = r_reqc + 9'd1;
          w_resp_rdy = 1'b1;
          w_timer    = '0;
          w_state    = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (cache.cacheresp_val) begin
          w_resp_rdy = 1'b0;
          w_respc    = r_respc + 9'd1;
          if (w_mismatch && (r_err != 8'hFF)) w_err = r_err + 8'd1;
          if (w_last_read) begin
            w_done  = 1'b1;
            w_pass  = (w_err == 8'd0) && !r_timeout;
            w_state = DONE;
          end else begin
            // Tag steps every request; index steps on each tag wrap.
            if (r_tag == TAG_LAST) begin
              w_tag = 3'd0;
              w_idx = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end else begin
              w_tag = r_tag + 3'd1;
            end
            // Last write: replay the same address/opaque sequence as reads.
            if (!r_rd && (r_seq == LAST_I)) begin
              w_rd  = 1'b1;
              w_seq = 8'd0;
              w_tag = 3'd0;
              w_idx = 3'd0;
            end else begin
              w_seq = r_seq + 8'd1;
            end
            if (GAP == 0) begin
              w_req_val = 1'b1;
              w_load    = 1'b1;
              w_state   = SEND;
            end else begin
              w_gap   = 8'd0;
              w_state = GAP_WAIT;
            end
          end
        end else if (r_timer == TO_LAST) begin
          w_resp_rdy = 1'b0;
          w_timeout  = 1'b1;
          w_done     = 1'b1;
          w_pass     = 1'b0;
          w_state    = DONE;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end

      default: w_state = IDLE;
    endcase

    // Message is rebuilt only on entry to SEND so it holds while stalled.
    if (w_load) begin
      w_req_msg = {w_rd ? T_RD : T_WR,
                   w_seq,
                   {20'd0, w_tag, w_idx, OFF, 2'b00},
                   2'b00,
                   w_rd ? 32'd0 : (DATA_SEED + {24'd0, w_seq})};
    end
  end

  // State register with synchronous reset that aborts any run in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_seq      <= 8'd0;
      r_tag      <= 3'd0;
      r_idx      <= 3'd0;
      r_rd       <= 1'b0;
      r_gap      <= 8'd0;
      r_timer    <= '0;
      r_req_val  <= 1'b0;
      r_req_msg  <= 76'd0;
      r_resp_rdy <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 8'd0;
      r_reqc     <= 9'd0;
      r_respc    <= 9'd0;
    end else begin
      r_state    <= w_state;
      r_seq      <= w_seq;
      r_tag      <= w_tag;
      r_idx      <= w_idx;
      r_rd       <= w_rd;
      r_gap      <= w_gap;
      r_timer    <= w_timer;
      r_req_val  <= w_req_val;
      r_req_msg  <= w_req_msg;
      r_resp_rdy <= w_resp_rdy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_timeout  <= w_timeout;
      r_err      <= w_err;
      r_reqc     <= w_reqc;
      r_respc    <= w_respc;
    end
  end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: two generators, each with a small cache model.
// Lane 0: 50 reqs, 8x8 tag/idx (no aliasing), GAP 0, TIMEOUT 20.
// Lane 1: 6 reqs, 2x2 tag/idx, OFFSET 5, GAP 3 (reads of i=0,1 alias i=4,5).
module tb_cache_traffic_gen;
  localparam logic [31:0] SEED = 32'h1234_5600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] start, clr, mute, stall_en, corrupt_en;
  logic [1:0] req_val, req_rdy, resp_val, resp_rdy;
  logic [1:0] busy, done, pass, tmo;
  logic [1:0][75:0] req_msg;
  logic [1:0][7:0]  errc;
  logic [1:0][8:0]  reqc, respc;

  // Expected request message for the i-th request of a run (both phases).
  function automatic logic [75:0] exp_msg(input int nr, input int tc, input int ic,
                                          input int off, input int i);
    logic rd; int j; logic [2:0] t, x; logic [3:0] o; logic [31:0] a, d;
    rd = (i >= nr);
    j  = rd ? i - nr : i;
    t  = 3'(j % tc);
    x  = 3'((j / tc) % ic);
    o  = 4'(off);
    a  = {20'd0, t, x, o, 2'b00};
    d  = rd ? 32'd0 : SEED + 32'(j);
    return {rd ? 2'd0 : 2'd1, 8'(j), a, 2'd0, d};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int NR = (k == 0) ? 50 : 6;
    localparam int TC = (k == 0) ? 8 : 2;
    localparam int IC = (k == 0) ? 8 : 2;
    localparam int OF = (k == 0) ? 0 : 5;
    localparam int GP = (k == 0) ? 0 : 3;

    cache_traffic_gen_if cif();

    cache_traffic_gen #(
      .NUM_REQS(NR), .TAG_COUNT(TC), .IDX_COUNT(IC), .OFFSET(OF),
      .DATA_SEED(SEED), .GAP(GP), .TIMEOUT(20)
    ) dut (
      .clk(clk), .reset(rst), .start(start[k]), .cache(cif),
      .busy(busy[k]), .done(done[k]), .pass(pass[k]), .timeout(tmo[k]),
      .err_count(errc[k]), .req_count(reqc[k]), .resp_count(respc[k])
    );

    logic [31:0] mem [64];
    logic        rv;
    logic [43:0] rmsg;
    int          stall_cnt, seq_i, bad, acc;
    logic [31:0] addr5;
    logic [75:0] q;

    assign q = cif.cachereq_msg;
    // Optional stall: refuse write opaque 3 for its first 5 cycles.
    assign cif.cachereq_rdy  = !(stall_en[k] && q[73:66] == 8'd3 &&
                                 q[75:74] == 2'd1 && stall_cnt < 5);
    assign cif.cacheresp_val = rv;
    assign cif.cacheresp_msg = rmsg;

    assign req_val[k]  = cif.cachereq_val;
    assign req_rdy[k]  = cif.cachereq_rdy;
    assign resp_val[k] = cif.cacheresp_val;
    assign resp_rdy[k] = cif.cacheresp_rdy;
    assign req_msg[k]  = cif.cachereq_msg;

    // Cache model: memory, one-cycle response, request sequence scoreboard
    always @(posedge clk) begin
      if (rst || clr[k]) begin
        rv <= 1'b0; stall_cnt <= 0; seq_i <= 0; bad <= 0; acc <= 0;
      end else begin
        if (cif.cachereq_val && !cif.cachereq_rdy) stall_cnt <= stall_cnt + 1;
        if (rv && cif.cacheresp_rdy) rv <= 1'b0;
        if (cif.cachereq_val && cif.cachereq_rdy) begin
          acc   <= acc + 1;
          seq_i <= seq_i + 1;
          if (q !== exp_msg(NR, TC, IC, OF, seq_i)) bad <= bad + 1;
          if (seq_i == 4) addr5 <= q[65:34];
          if (!mute[k]) begin
            rv <= 1'b1;
            if (q[75:74] == 2'd1) begin
              mem[q[45:40]] <= q[31:0];
              rmsg <= {2'd1, q[73:66], 2'd0, 32'd0};
            end else begin
              rmsg <= {2'd0, q[73:66], 2'd0,
                       mem[q[45:40]] ^ ((corrupt_en[k] && q[73:66] == 8'd7) ? 32'h1 : 32'h0)};
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input int k);
    @(negedge clk);
    start[k] = 1'b1; clr[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0; clr[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done[k] && n < 3000) begin @(negedge clk); n++; end
    chk("done_reached", 76'(done[k]), 76'd1);
  endtask

  task automatic wait_resp_hs(input int k, output logic ok);
    int n;
    n = 0;
    while (!(resp_val[k] && resp_rdy[k]) && n < 200) begin @(negedge clk); n++; end
    ok = resp_val[k] && resp_rdy[k];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_val"},   76'(req_val[0]),  76'd0);
    chk({tag, "_rdy"},   76'(resp_rdy[0]), 76'd0);
    chk({tag, "_msg"},   76'(req_msg[0]),  76'd0);
    chk({tag, "_busy"},  76'(busy[0]),     76'd0);
    chk({tag, "_done"},  76'(done[0]),     76'd0);
    chk({tag, "_pass"},  76'(pass[0]),     76'd0);
    chk({tag, "_tmo"},   76'(tmo[0]),      76'd0);
    chk({tag, "_err"},   76'(errc[0]),     76'd0);
    chk({tag, "_reqc"},  76'(reqc[0]),     76'd0);
    chk({tag, "_respc"}, 76'(respc[0]),    76'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   cnt, n;

    rst = 1'b1; start = '0; clr = '0; mute = '0; stall_en = '0; corrupt_en = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_val", 76'(req_val[0]), 76'd0);

    // Ideal run
    run_start(0);
    chk("first_val",  76'(req_val[0]), 76'd1);
    chk("first_msg",  req_msg[0], {2'd1, 8'd0, 32'd0, 2'd0, SEED});
    chk("first_busy", 76'(busy[0]), 76'd1);
    wait_resp_hs(0, ok);
    chk("first_resp_seen", 76'(ok), 76'd1);
    @(negedge clk);
    chk("gap0_val", 76'(req_val[0]), 76'd1);
    chk("gap0_msg", req_msg[0], {2'd1, 8'd1, 32'h200, 2'd0, SEED + 32'd1});
    wait_done(0);
    chk("ideal_reqc",  76'(reqc[0]),  76'd100);
    chk("ideal_respc", 76'(respc[0]), 76'd100);
    chk("ideal_err",   76'(errc[0]),  76'd0);
    chk("ideal_pass",  76'(pass[0]),  76'd1);
    chk("ideal_busy",  76'(busy[0]),  76'd0);
    chk("ideal_tmo",   76'(tmo[0]),   76'd0);
    chk("ideal_addr5", 76'(g_lane[0].addr5), 76'h800);
    chk("ideal_seq",   76'(g_lane[0].bad),   76'd0);
    chk("ideal_acc",   76'(g_lane[0].acc),   76'd100);
    repeat (3) @(negedge clk);
    chk("done_hold",   76'(done[0]),  76'd1);
    chk("pass_hold",   76'(pass[0]),  76'd1);

    // Corrupted read data for opaque 7, restarted from DONE
    corrupt_en[0] = 1'b1;
    run_start(0);
    chk("restart_done_clr", 76'(done[0]), 76'd0);
    wait_done(0);
    chk("corrupt_err",   76'(errc[0]),  76'd1);
    chk("corrupt_pass",  76'(pass[0]),  76'd0);
    chk("corrupt_respc", 76'(respc[0]), 76'd100);
    corrupt_en[0] = 1'b0;

    // Back-pressure on request 3
    stall_en[0] = 1'b1;
    run_start(0);
    n = 0;
    while (!(req_val[0] && !req_rdy[0]) && n < 100) begin @(negedge clk); n++; end
    chk("stall_seen", 76'(req_val[0] && !req_rdy[0]), 76'd1);
    for (int s = 0; s < 5; s++) begin
      chk("stall_val", 76'(req_val[0]), 76'd1);
      chk("stall_msg", req_msg[0], {2'd1, 8'd3, 32'h600, 2'd0, SEED + 32'd3});
      @(negedge clk);
    end
    chk("stall_release", 76'(req_rdy[0]), 76'd1);
    wait_done(0);
    chk("stall_reqc", 76'(reqc[0]), 76'd100);
    chk("stall_acc",  76'(g_lane[0].acc), 76'd100);
    chk("stall_seq",  76'(g_lane[0].bad), 76'd0);
    chk("stall_pass", 76'(pass[0]), 76'd1);
    stall_en[0] = 1'b0;

    // No response to request 0: timeout after 20 cycles in WAIT_RESP
    mute[0] = 1'b1;
    run_start(0);
    chk("to_req_val", 76'(req_val[0] && req_rdy[0]), 76'd1);
    @(posedge clk);
    cnt = 0;
    while (!tmo[0] && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("to_cycles", 76'(cnt), 76'd20);
    chk("to_flag",   76'(tmo[0]),   76'd1);
    chk("to_done",   76'(done[0]),  76'd1);
    chk("to_pass",   76'(pass[0]),  76'd0);
    chk("to_reqc",   76'(reqc[0]),  76'd1);
    chk("to_respc",  76'(respc[0]), 76'd0);
    chk("to_busy",   76'(busy[0]),  76'd0);
    chk("to_rdy",    76'(resp_rdy[0]), 76'd0);
    mute[0] = 1'b0;

    // Reset while waiting on request 10's response
    run_start(0);
    n = 0;
    while (!(req_val[0] && req_rdy[0] && req_msg[0][73:66] == 8'd10) && n < 200) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("mid_wait_rdy", 76'(resp_rdy[0]), 76'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    @(negedge clk);
    chk("midrst_hold_val", 76'(req_val[0]), 76'd0);
    rst = 1'b0;
    run_start(0);
    chk("rerun_msg", req_msg[0], {2'd1, 8'd0, 32'd0, 2'd0, SEED});
    wait_done(0);
    chk("rerun_pass", 76'(pass[0]), 76'd1);
    chk("rerun_reqc", 76'(reqc[0]), 76'd100);
    chk("rerun_seq",  76'(g_lane[0].bad), 76'd0);

    // Lane 1: GAP=3, start pulsed while busy, aliased addresses
    run_start(1);
    chk("g_first_msg", req_msg[1], {2'd1, 8'd0, 32'h14, 2'd0, SEED});
    for (int g = 0; g < 11; g++) begin
      wait_resp_hs(1, ok);
      chk("g_resp_seen", 76'(ok), 76'd1);
      cnt = 0;
      @(negedge clk);
      while (!req_val[1] && cnt < 20) begin
        cnt++;
        start[1] = (g == 0 && cnt == 1);
        @(negedge clk);
      end
      start[1] = 1'b0;
      chk("g_gap_len", 76'(cnt), 76'd3);
    end
    wait_done(1);
    chk("g_reqc",  76'(reqc[1]),  76'd12);
    chk("g_respc", 76'(respc[1]), 76'd12);
    chk("g_err",   76'(errc[1]),  76'd2);
    chk("g_pass",  76'(pass[1]),  76'd0);
    chk("g_tmo",   76'(tmo[1]),   76'd0);
    chk("g_seq",   76'(g_lane[1].bad), 76'd0);
    chk("g_acc",   76'(g_lane[1].acc), 76'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
